// File: rtl/bsg_credit_return_fifo_if.sv
// Handshake bundle for the credit-return FIFO.
// The slave modport is the FIFO itself. The master modport is the environment,
// which acts as both the sender and the consumer.
interface bsg_credit_return_fifo_if #(
    parameter int width_p = 8,
    parameter int els_p   = 9
);
    localparam int cnt_w = $clog2(els_p + 1);

    logic               v_i;
    logic [width_p-1:0] data_i;
    logic               v_o;
    logic [width_p-1:0] data_o;
    logic               yumi_i;
    logic               credit_o;
    logic [cnt_w-1:0]   count_o;
    logic               overflow_o;

    modport slave (
        input  v_i, data_i, yumi_i,
        output v_o, data_o, credit_o, count_o, overflow_o
    );

    modport master (
        output v_i, data_i, yumi_i,
        input  v_o, data_o, credit_o, count_o, overflow_o
    );
endinterface

// File: rtl/bsg_credit_return_fifo.sv
// Credit-return receive FIFO.
// The sender holds an up/down credit counter that starts at els_p. Each
// accepted dequeue returns one credit to it one cycle later. Because credits
// gate the sender, there is no ready signal. If the sender sends while the
// buffer is full and nothing leaves, that is a protocol error: the beat is
// dropped and a sticky overflow flag is raised.
module bsg_credit_return_fifo #(
    parameter int width_p = 8,
    parameter int els_p   = 9
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    bsg_credit_return_fifo_if.slave  bus
);
    localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w = $clog2(els_p + 1);
    localparam logic [ptr_w-1:0] last_ptr = ptr_w'(els_p - 1);
    localparam logic [cnt_w-1:0] full_cnt = cnt_w'(els_p);

    logic [width_p-1:0] r_mem [els_p];
    logic [ptr_w-1:0]   r_rptr;
    logic [ptr_w-1:0]   r_wptr;
    logic [cnt_w-1:0]   r_count;
    logic               r_credit;
    logic               r_overflow;

    logic               w_deq;
    logic               w_enq;
    logic               w_drop;

    // Accept/drop decisions. These depend only on registered state plus the
    // same-cycle inputs, so a full buffer can take a new beat while its head leaves.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_deq  = 1'b0;
        w_enq  = 1'b0;
        w_drop = 1'b0;
        w_deq  = bus.yumi_i && (r_count != '0);
        w_enq  = bus.v_i && ((r_count != full_cnt) || w_deq);
        w_drop = bus.v_i && !w_enq;
    end

    // Payload storage: write-only on accepted enqueues.
    // NOTE: the storage array has no reset. Stale contents are never visible, because v_o is driven by the occupancy count and not by the array.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_wptr] <= bus.data_i;
        end
    end

    // Pointers, occupancy, credit pulse and sticky overflow flag.
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_rptr     <= '0;
            r_wptr     <= '0;
            r_count    <= '0;
            r_credit   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_enq) begin
                r_wptr <= (r_wptr == last_ptr) ? '0 : r_wptr + 1'b1;
            end
            if (w_deq) begin
                r_rptr <= (r_rptr == last_ptr) ? '0 : r_rptr + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_credit <= w_deq;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.v_o        = (r_count != '0);
    assign bus.data_o     = r_mem[r_rptr];
    assign bus.credit_o   = r_credit;
    assign bus.count_o    = r_count;
    assign bus.overflow_o = r_overflow;
endmodule

// File: doc/bsg_credit_return_fifo.md
BSG_CREDIT_RETURN_FIFO -- requirements
Module: bsg_credit_return_fifo

Interface
REQ-001 SHALL have parameter width_p, default 8, payload width in bits.
REQ-002 SHALL have parameter els_p, default 9, number of buffer entries; equals the sender's credit-counter maximum value; need not be a power of two.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port v_i  input  1  sender data valid; no ready signal, because sender credits gate it.
REQ-006 SHALL have port data_i  input  width_p  sender payload.
REQ-007 SHALL have port v_o  output  1  head entry valid to the consumer.
REQ-008 SHALL have port data_o  output  width_p  head entry payload.
REQ-009 SHALL have port yumi_i  input  1  consumer takes the head entry this cycle.
REQ-010 SHALL have port credit_o  output  1  one-cycle credit-return pulse to the sender's up/down counter.
REQ-011 SHALL have port count_o  output  $clog2(els_p+1)  current occupancy.
REQ-012 SHALL have port overflow_o  output  1  sticky protocol-error flag.

Function
REQ-013 SHALL store entries in a circular buffer with read and write pointers of width $clog2(els_p); each pointer SHALL wrap from els_p-1 to 0.
REQ-014 SHALL accept an enqueue when v_i=1 and (count_o<els_p or a dequeue is accepted in the same cycle); it SHALL write data_i at the write pointer and advance that pointer.
REQ-015 SHALL drop v_i when count_o==els_p and no dequeue occurs in the same cycle; it SHALL leave the pointers and count unchanged and set overflow_o=1.
REQ-016 SHALL hold overflow_o at 1 until reset.
REQ-017 SHALL drive v_o = (count_o!=0), registered-state derived, with no combinational path from v_i.
REQ-018 SHALL drive data_o from the entry at the read pointer; data_o is don't-care when v_o=0.
REQ-019 SHALL accept a dequeue only when yumi_i=1 and v_o=1; yumi_i with v_o=0 SHALL be ignored and SHALL produce no credit.
REQ-020 SHALL advance the read pointer by one on an accepted dequeue.
REQ-021 SHALL update count_o each cycle as count + enq_accepted - deq_accepted; it SHALL never exceed els_p or go below 0.
REQ-022 SHALL NOT bypass: data enqueued in cycle N SHALL first appear on data_o with v_o=1 in cycle N+1.
REQ-023 SHALL register credit_o: it SHALL be 1 in cycle N+1 exactly when a dequeue was accepted in cycle N, and 0 otherwise.
REQ-024 SHALL NOT generate credit for dropped (overflow) enqueues.
REQ-025 SHALL, when the buffer is full and v_i and yumi_i arrive in the same cycle, dequeue the head, enqueue the new data, keep count_o=els_p, pulse credit_o next cycle and leave overflow_o=0.
REQ-026 SHALL, when the buffer is empty and v_i and yumi_i arrive in the same cycle, enqueue only; count_o SHALL become 1 and no credit SHALL be issued.

Reset
REQ-027 SHALL, on reset_i=1 and independent of clk_i, force both pointers to 0, count_o to 0, v_o to 0, credit_o to 0 and overflow_o to 0.
REQ-028 SHALL NOT reset buffer storage.
REQ-029 SHALL, when reset is asserted mid-operation, discard all entries and any pending credit pulse.
REQ-030 SHALL accept enqueues on the first rising edge after reset_i deasserts.

Verification
REQ-031 Fill/drain: 9 back-to-back enqueues of 0x01..0x09, then yumi_i held high -> count_o reaches 9; data_o reads 0x01..0x09 in order; 9 credit_o pulses, each one cycle after its dequeue.
REQ-032 Overflow: fill to 9, then v_i=1 with data 0xAA and yumi_i=0 -> count_o stays 9, overflow_o=1 and stays 1, 0xAA is never output, no credit.
REQ-033 Full simultaneous: full, v_i=1 with 0x55 and yumi_i=1 -> count_o stays 9, credit_o=1 next cycle, overflow_o=0, 0x55 emerges after the 8 older entries.
REQ-034 Wrap-around: 30 cycles of random enqueue/dequeue while occupancy stays below 9 -> pointers cross 8->0 with no data loss, and total credit pulses equal total dequeues.
REQ-035 Async reset: with count_o=5 and a dequeue just accepted, assert reset_i between clock edges -> v_o, count_o, credit_o and overflow_o are 0 immediately; the next enqueue after deassertion gives count_o=1.
REQ-036 Empty corner: empty, yumi_i=1 alone -> no credit and count_o stays 0; then v_i=1 and yumi_i=1 together -> count_o=1 and no credit.
